// File: rtl/register_file_32x32_pkg.sv
// Purpose : shared widths, the hardwired-zero address and the word type for the register file.
// Latency : n/a (definitions only).
// Backpressure: n/a.
package register_file_32x32_pkg;

    localparam int REG_DATA_WIDTH = 32;
    localparam int REG_ADDR_WIDTH = 5;

    // Register 0 reads as zero and ignores writes.
    localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = 5'd0;

    typedef logic [REG_DATA_WIDTH-1:0] reg_word_t;

endpackage

// File: rtl/rf_read_port.sv
// Purpose : one combinational read port with a zero-register check and a write-through bypass.
// Latency : zero cycles (pure combinational).
// Backpressure: none; the port is always ready.
//
// Ports:
//   i_rd_addr        address being read
//   i_wr_en/addr/dat write port seen this cycle (i_wr_en must already be qualified by reset)
//   i_regs           stored register contents
//   o_rd_dat         value returned to the datapath
module rf_read_port
    import register_file_32x32_pkg::*;
#(
    parameter int DATA_WIDTH = REG_DATA_WIDTH,
    parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
    parameter int DEPTH      = 2**ADDR_WIDTH
) (
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_dat,
    input  logic [DATA_WIDTH-1:0] i_regs [DEPTH],
    output logic [DATA_WIDTH-1:0] o_rd_dat
);

    logic w_is_zero;
    logic w_bypass;

    assign w_is_zero = (i_rd_addr == ADDR_WIDTH'(REG_ZERO));
    // Forward the writeback value so decode sees it in the same cycle it is written.
    assign w_bypass  = i_wr_en && (i_wr_addr == i_rd_addr);

    always_comb begin
        o_rd_dat = i_regs[i_rd_addr];
        if (w_is_zero) begin
            o_rd_dat = '0;
        end else if (w_bypass) begin
            o_rd_dat = i_wr_dat;
        end
    end

endmodule

// File: rtl/register_file_32x32.sv
// Purpose : 32x32 register file, two bypassed combinational read ports, one write port, five debug taps.
// Latency : reads 0 cycles; writes visible in storage after the next rising clk edge.
// Backpressure: none; every cycle accepts one write and serves two reads.
//
// Ports:
//   clk, reset (async, active-low; clears every register)
//   wr_enable3/write_addr3/write_data3  writeback port (address 0 discarded)
//   read_addr1/read_data1, read_addr2/read_data2  operand read ports with write-through bypass
//   read_data_to_debug_0..4  stored contents of registers 0..4 (never bypassed)
module register_file_32x32
    import register_file_32x32_pkg::*;
#(
    parameter int DATA_WIDTH = REG_DATA_WIDTH,
    parameter int ADDR_WIDTH = REG_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_enable3,
    input  logic [ADDR_WIDTH-1:0] read_addr1,
    input  logic [ADDR_WIDTH-1:0] read_addr2,
    input  logic [ADDR_WIDTH-1:0] write_addr3,
    input  logic [DATA_WIDTH-1:0] write_data3,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2,
    output logic [DATA_WIDTH-1:0] read_data_to_debug_0,
    output logic [DATA_WIDTH-1:0] read_data_to_debug_1,
    output logic [DATA_WIDTH-1:0] read_data_to_debug_2,
    output logic [DATA_WIDTH-1:0] read_data_to_debug_3,
    output logic [DATA_WIDTH-1:0] read_data_to_debug_4
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] w_regs [DEPTH];
    logic                  w_wr_en;

    // Gating with reset keeps the bypass from leaking write data onto the
    // read ports while the file is held cleared.
    assign w_wr_en = wr_enable3 & reset;

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_reg
            if (g == 0) begin : g_zero
                assign w_regs[g] = '0;
            end else begin : g_word
                logic [DATA_WIDTH-1:0] r_word;
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        r_word <= '0;
                    end else if (w_wr_en && (write_addr3 == ADDR_WIDTH'(g))) begin
                        r_word <= write_data3;
                    end
                end
                assign w_regs[g] = r_word;
            end
        end
    endgenerate

    rf_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_rd_port1 (
        .i_rd_addr (read_addr1),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (write_addr3),
        .i_wr_dat  (write_data3),
        .i_regs    (w_regs),
        .o_rd_dat  (read_data1)
    );

    rf_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_rd_port2 (
        .i_rd_addr (read_addr2),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (write_addr3),
        .i_wr_dat  (write_data3),
        .i_regs    (w_regs),
        .o_rd_dat  (read_data2)
    );

    // Taps show stored state only; register 0 is the constant-zero entry.
    assign read_data_to_debug_0 = w_regs[0];
    assign read_data_to_debug_1 = w_regs[1];
    assign read_data_to_debug_2 = w_regs[2];
    assign read_data_to_debug_3 = w_regs[3];
    assign read_data_to_debug_4 = w_regs[4];

endmodule

// File: tb/tb_register_file_32x32.sv
// Purpose : directed, table-driven checks of register_file_32x32 plus reset corner sequences.
// Latency : n/a.
// Backpressure: n/a.
module tb_register_file_32x32;
    import register_file_32x32_pkg::*;

    logic        clk;
    logic        reset;
    logic        wr_enable3;
    logic [4:0]  read_addr1, read_addr2, write_addr3;
    reg_word_t   write_data3;
    reg_word_t   read_data1, read_data2;
    reg_word_t   dbg0, dbg1, dbg2, dbg3, dbg4;

    int n_pass  = 0;
    int n_total = 0;

    register_file_32x32 dut (
        .clk                  (clk),
        .reset                (reset),
        .wr_enable3           (wr_enable3),
        .read_addr1           (read_addr1),
        .read_addr2           (read_addr2),
        .write_addr3          (write_addr3),
        .write_data3          (write_data3),
        .read_data1           (read_data1),
        .read_data2           (read_data2),
        .read_data_to_debug_0 (dbg0),
        .read_data_to_debug_1 (dbg1),
        .read_data_to_debug_2 (dbg2),
        .read_data_to_debug_3 (dbg3),
        .read_data_to_debug_4 (dbg4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic      we;
        logic [4:0] ra1, ra2, wa;
        reg_word_t wd;
        reg_word_t e1, e2;              // read ports before the edge
        reg_word_t d1, d2, d3, d4;      // debug taps after the edge
    } vec_t;

    vec_t tbl [12];

    function automatic vec_t mk(input logic we, input logic [4:0] ra1, input logic [4:0] ra2,
                                input logic [4:0] wa, input reg_word_t wd,
                                input reg_word_t e1, input reg_word_t e2,
                                input reg_word_t d1, input reg_word_t d2,
                                input reg_word_t d3, input reg_word_t d4);
        vec_t v;
        v.we = we; v.ra1 = ra1; v.ra2 = ra2; v.wa = wa; v.wd = wd;
        v.e1 = e1; v.e2 = e2; v.d1 = d1; v.d2 = d2; v.d3 = d3; v.d4 = d4;
        return v;
    endfunction

    task automatic chk(input string nm, input reg_word_t act, input reg_word_t exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic chk_dbg(input string tag, input reg_word_t d1, input reg_word_t d2,
                           input reg_word_t d3, input reg_word_t d4);
        chk({tag, " dbg0"}, dbg0, 32'h0);
        chk({tag, " dbg1"}, dbg1, d1);
        chk({tag, " dbg2"}, dbg2, d2);
        chk({tag, " dbg3"}, dbg3, d3);
        chk({tag, " dbg4"}, dbg4, d4);
    endtask

    task automatic chk_reads(input string tag, input reg_word_t e1, input reg_word_t e2);
        chk({tag, " rd1"}, read_data1, e1);
        chk({tag, " rd2"}, read_data2, e2);
    endtask

    initial begin
        reg_word_t p1, p2, p3, p4;
        string     tag;

        //         we  ra1 ra2 wa  wd            e1            e2            d1            d2            d3            d4
        tbl[0]  = mk(1, 1,  0,  1, 32'h00000003, 32'h00000003, 32'h00000000, 32'h00000003, 32'h0,        32'h0,        32'h0);
        tbl[1]  = mk(0, 1,  1,  1, 32'h00000007, 32'h00000003, 32'h00000003, 32'h00000003, 32'h0,        32'h0,        32'h0);
        tbl[2]  = mk(1, 0,  1,  0, 32'hDEADBEEF, 32'h00000000, 32'h00000003, 32'h00000003, 32'h0,        32'h0,        32'h0);
        tbl[3]  = mk(1, 1,  2,  1, 32'h11111111, 32'h11111111, 32'h00000000, 32'h11111111, 32'h0,        32'h0,        32'h0);
        tbl[4]  = mk(1, 1,  2,  2, 32'h22222222, 32'h11111111, 32'h22222222, 32'h11111111, 32'h22222222, 32'h0,        32'h0);
        tbl[5]  = mk(1, 3,  3,  3, 32'h33333333, 32'h33333333, 32'h33333333, 32'h11111111, 32'h22222222, 32'h33333333, 32'h0);
        tbl[6]  = mk(1, 2,  4,  4, 32'h44444444, 32'h22222222, 32'h44444444, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
        tbl[7]  = mk(1, 4, 31, 31, 32'hA5A5A5A5, 32'h44444444, 32'hA5A5A5A5, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
        tbl[8]  = mk(0, 31, 4, 31, 32'hFFFFFFFF, 32'hA5A5A5A5, 32'h44444444, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
        tbl[9]  = mk(0, 31, 31, 31, 32'h12345678, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
        tbl[10] = mk(1, 31, 5,  5, 32'h55555555, 32'hA5A5A5A5, 32'h55555555, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
        tbl[11] = mk(1, 5,  1,  1, 32'h00000000, 32'h55555555, 32'h00000000, 32'h00000000, 32'h22222222, 32'h33333333, 32'h44444444);

        // Reset held low with a write pending: nothing may change.
        reset = 1'b0; wr_enable3 = 1'b1;
        read_addr1 = 5'd18; read_addr2 = 5'd26; write_addr3 = 5'd1; write_data3 = 32'h3;
        #1;
        chk_reads("reset initial", 32'h0, 32'h0);
        chk_dbg("reset initial", 32'h0, 32'h0, 32'h0, 32'h0);
        repeat (10) @(posedge clk);
        #1;
        chk_reads("reset 10 edges", 32'h0, 32'h0);
        chk_dbg("reset 10 edges", 32'h0, 32'h0, 32'h0, 32'h0);

        // Release between edges; the very next edge performs the first write.
        @(negedge clk);
        reset = 1'b1;
        p1 = 32'h0; p2 = 32'h0; p3 = 32'h0; p4 = 32'h0;
        for (int i = 0; i < 12; i++) begin
            wr_enable3  = tbl[i].we;
            read_addr1  = tbl[i].ra1;
            read_addr2  = tbl[i].ra2;
            write_addr3 = tbl[i].wa;
            write_data3 = tbl[i].wd;
            #1;
            tag = $sformatf("vec%0d pre", i);
            chk_reads(tag, tbl[i].e1, tbl[i].e2);
            // Taps never bypass: before the edge they show the prior state.
            chk_dbg(tag, p1, p2, p3, p4);
            @(posedge clk);
            #1;
            tag = $sformatf("vec%0d post", i);
            chk_dbg(tag, tbl[i].d1, tbl[i].d2, tbl[i].d3, tbl[i].d4);
            p1 = tbl[i].d1; p2 = tbl[i].d2; p3 = tbl[i].d3; p4 = tbl[i].d4;
            @(negedge clk);
        end

        // Confirm reg 31 and reg 5 retained their values through the table.
        wr_enable3 = 1'b0; read_addr1 = 5'd31; read_addr2 = 5'd5; write_data3 = 32'hCAFEF00D;
        #1;
        chk_reads("hold 31/5", 32'hA5A5A5A5, 32'h55555555);

        // Asynchronous reset between edges with a write pending.
        @(negedge clk);
        wr_enable3 = 1'b1; write_addr3 = 5'd2; write_data3 = 32'h00000099;
        read_addr1 = 5'd31; read_addr2 = 5'd2;
        #1;
        chk_reads("pre async", 32'hA5A5A5A5, 32'h00000099);
        #1;
        reset = 1'b0;
        #1;
        chk_reads("async now", 32'h0, 32'h0);
        chk_dbg("async now", 32'h0, 32'h0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        chk_reads("async edge", 32'h0, 32'h0);
        chk_dbg("async edge", 32'h0, 32'h0, 32'h0, 32'h0);

        // Release with no write: everything stays cleared.
        @(negedge clk);
        reset = 1'b1; wr_enable3 = 1'b0; read_addr1 = 5'd5; read_addr2 = 5'd4;
        @(posedge clk);
        #1;
        chk_reads("after release", 32'h0, 32'h0);
        chk_dbg("after release", 32'h0, 32'h0, 32'h0, 32'h0);
        read_addr1 = 5'd31; read_addr2 = 5'd2;
        #1;
        chk_reads("after release 31/2", 32'h0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/register_file_32x32.md
Name: register_file_32x32

Overview:
- 32-entry x 32-bit general-purpose register file for the MIPS-style CPU datapath.
- Two combinational read ports (rs/rt operands) and one synchronous write port (port 3, writeback).
- Five fixed debug taps expose registers 0..4 to the debug unit without consuming read ports.
- Register 0 is hardwired to zero.

Parameters:
- DATA_WIDTH, 32, width of each register and of all data ports
- ADDR_WIDTH, 5, register address width; depth = 2**ADDR_WIDTH = 32

Ports:
- clk  input  1  system clock; all writes on rising edge
- reset  input  1  asynchronous, active-low reset; 0 clears the file
- wr_enable3  input  1  write enable for write port 3
- read_addr1  input  ADDR_WIDTH  read port 1 address
- read_addr2  input  ADDR_WIDTH  read port 2 address
- write_addr3  input  ADDR_WIDTH  write port 3 address
- write_data3  input  DATA_WIDTH  write port 3 data
- read_data1  output  DATA_WIDTH  contents at read_addr1
- read_data2  output  DATA_WIDTH  contents at read_addr2
- read_data_to_debug_0..read_data_to_debug_4  output  DATA_WIDTH each  contents of registers 0..4 respectively

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (reset = 0 asserts).
- Reset: while reset = 0, all 32 registers clear to 0 immediately, independent of clk. All outputs therefore read 0. Writes are ignored while reset is low.
- Write timing: on a rising clk edge with reset = 1, wr_enable3 = 1 and write_addr3 != 0, register[write_addr3] <= write_data3. A write to address 0 is discarded.
- Reads: read_data1/2 are purely combinational from their address with zero-cycle latency. Address 0 always returns 0.
- Write-through bypass: if wr_enable3 = 1, write_addr3 != 0 and write_addr3 equals a read address, that read port returns write_data3 in the same cycle before the edge. This lets a pipelined writeback and decode share a cycle.
- Bypass applies independently to each port. Both ports may read the same address.
- Debug taps: read_data_to_debug_k = register[k] for k = 0..4.
  - Combinational from stored state only; no bypass.
  - read_data_to_debug_0 is always 0.
- Reset mid-operation: asserting reset overrides any same-cycle write. The register contents are cleared, not the pending write data.
- Reset deassertion: the first write can occur on the first rising edge after reset returns to 1.
- Addresses need no range checks, since every 5-bit value is a valid register.
- No X propagation: registers are always initialised by reset.

Decomposition:
- Shared package holds REG_DATA_WIDTH = 32, REG_ADDR_WIDTH = 5, REG_ZERO = 5'd0, and a typedef reg_word_t (32-bit logic).
- Single module; storage is an array of 32 words with a generate loop for the reset/write logic.
- The bypassed read mux (address, zero check, bypass compare) is instanced twice. Factor it as sub-module rf_read_port.

Test Plan:
- Hold reset = 0, drive read_addr1 = 18, read_addr2 = 26, write_addr3 = 1, write_data3 = 3, wr_enable3 = 1 for 10 edges -> read_data1/2 and all debug taps stay 0; no write occurs.
- Release reset = 1, keep write_addr3 = 1, write_data3 = 3, wr_enable3 = 1, read_addr1 = 1 -> read_data1 = 3 before the edge (bypass). After the edge, read_data_to_debug_1 = 3 and it persists once wr_enable3 = 0.
- Write 0xDEADBEEF to address 0 with wr_enable3 = 1, read_addr1 = 0 -> read_data1 = 0 and read_data_to_debug_0 = 0 both before and after the edge.
- Write 0x11111111..0x44444444 to registers 1..4 and 0xA5A5A5A5 to register 31, then read_addr1 = 31, read_addr2 = 4 -> read_data1 = 0xA5A5A5A5, read_data2 = 0x44444444, debug taps 1..4 = 0x11111111..0x44444444.
- Same-address dual read: read_addr1 = read_addr2 = 31 -> both ports return 0xA5A5A5A5. With wr_enable3 = 0, changing write_data3 does not affect either port.
- Pull reset low asynchronously mid-cycle (between edges) with a write pending -> all registers and outputs 0 immediately. After release with wr_enable3 = 0, everything stays 0.
